// File: rtl/fsrcnn_pkg.sv
// Shared types and constants for the FSRCNN input fetch path.
package fsrcnn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   localparam logic [2:0] ST_COMPUTE = 3'd2;
   localparam int         FIFO_DEPTH = 3;

endpackage

// File: rtl/fetch_fifo.sv
// Three-entry skid FIFO that absorbs the input-buffer read latency.
// Holds read data plus its end-of-row tag in the MSB.
module fetch_fifo
   import fsrcnn_pkg::*;
#(
   parameter int W = 257
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   occ,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem [FIFO_DEPTH];
   logic [1:0]   wr_ptr;
   logic [1:0]   rd_ptr;
   logic         do_push;
   logic         do_pop;

   function automatic logic [1:0] bump(input logic [1:0] p);
      return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign full    = (occ == 2'(FIFO_DEPTH));
   assign empty   = (occ == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Empty FIFO presents zeros so the stream outputs are quiet after reset/flush.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         occ    <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         occ <= occ + 2'(do_push) - 2'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/input_fetcher.sv
// Walks a rows x cols tile of the input buffer during compute and streams the
// words out as valid/ready with end-of-row markers.
module input_fetcher
   import fsrcnn_pkg::*;
#(
   parameter int DW = 256,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    top_level_state,
   input  logic          start,
   input  logic [AW-1:0] base_ra,
   input  logic [AW-1:0] row_stride,
   input  logic [AW-1:0] num_rows,
   input  logic [AW-1:0] num_cols,
   output logic          a_re,
   output logic [AW-1:0] a_ra,
   input  logic [DW-1:0] a_rd,
   output logic          f_valid,
   output logic [DW-1:0] f_data,
   output logic          f_last,
   input  logic          f_ready,
   output logic          busy,
   output logic          fetch_done,
   output fetch_state_t  fsm_state
);

   // Stream handshake: a word transfers on a cycle with f_valid & f_ready;
   // while f_valid & !f_ready, f_valid stays high and f_data/f_last hold.

   fetch_state_t  state;
   fetch_state_t  state_nxt;
   logic [AW-1:0] base_q;
   logic [AW-1:0] stride_q;
   logic [AW-1:0] rows_q;
   logic [AW-1:0] cols_q;
   logic [AW-1:0] row;
   logic [AW-1:0] col;
   logic [AW-1:0] row_off;
   logic          inflight;
   logic          tag_q;
   logic          active;
   logic          credit_ok;
   logic          issue;
   logic          last_col;
   logic          last_row;
   logic          pop;
   logic          drain_done;
   logic          flush;
   logic          full;
   logic          empty;
   logic [1:0]    occ;
   logic [DW:0]   fifo_dout;

   assign active    = (top_level_state == ST_COMPUTE);
   assign credit_ok = !full && ((3'(occ) + 3'(inflight)) < 3'(FIFO_DEPTH));
   assign last_col  = (col == cols_q);
   assign last_row  = (row == rows_q);
   assign issue     = (state == FETCH) && active && credit_ok;
   assign a_re      = issue;
   assign a_ra      = issue ? (base_q + row_off + col) : '0;
   assign pop       = f_valid && f_ready;
   // Leave DRAIN on the cycle the final word pops, so fetch_done follows the last handshake directly.
   assign drain_done = !inflight && (occ == 2'(pop));
   assign flush     = (state != IDLE) && !active;
   assign busy      = (state != IDLE);
   assign fsm_state = state;
   assign f_valid   = !empty;
   assign f_data    = fifo_dout[DW-1:0];
   assign f_last    = fifo_dout[DW];

   always_comb begin
      state_nxt  = state;
      fetch_done = 1'b0;
      case (state)
         IDLE:  if (start && active) state_nxt = FETCH;
         FETCH: begin
            if (!active)                             state_nxt = IDLE;
            else if (issue && last_col && last_row)  state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!active)         state_nxt = IDLE;
            else if (drain_done) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
            if (active) fetch_done = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         inflight <= 1'b0;
         tag_q    <= 1'b0;
         base_q   <= '0;
         stride_q <= '0;
         rows_q   <= '0;
         cols_q   <= '0;
         row      <= '0;
         col      <= '0;
         row_off  <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (issue) tag_q <= last_col;
         if (state == IDLE && start && active) begin
            base_q   <= base_ra;
            stride_q <= row_stride;
            rows_q   <= num_rows;
            cols_q   <= num_cols;
            row      <= '0;
            col      <= '0;
            row_off  <= '0;
         end else if (issue) begin
            if (last_col) begin
               col     <= '0;
               row     <= row + AW'(1);
               row_off <= row_off + stride_q;
            end else begin
               col <= col + AW'(1);
            end
         end
      end
   end

   fetch_fifo #(
      .W(DW + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (inflight),
      .din   ({tag_q, a_rd}),
      .pop   (pop),
      .dout  (fifo_dout),
      .occ   (occ),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_input_fetcher.sv
// Directed bench for input_fetcher: tile walks, backpressure, wrap, ignored starts,
// abort and mid-run reset, checked against a row-major tile model.
module tb_input_fetcher;
  import fsrcnn_pkg::*;

  localparam int DW = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    top_level_state;
  logic          start;
  logic [AW-1:0] base_ra, row_stride, num_rows, num_cols;
  logic          a_re;
  logic [AW-1:0] a_ra;
  logic [DW-1:0] a_rd;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic          f_last;
  logic          f_ready;
  logic          busy;
  logic          fetch_done;
  fetch_state_t  fsm_state;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  int issued = 0;
  int popped = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_data_q[$];
  bit            done_due = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;

  input_fetcher #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .top_level_state(top_level_state), .start(start),
    .base_ra(base_ra), .row_stride(row_stride), .num_rows(num_rows), .num_cols(num_cols),
    .a_re(a_re), .a_ra(a_ra), .a_rd(a_rd),
    .f_valid(f_valid), .f_data(f_data), .f_last(f_last), .f_ready(f_ready),
    .busy(busy), .fetch_done(fetch_done), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model ----------------
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {8{8'hC0, a, ~a, a ^ 8'h5A}};
  endfunction

  always @(posedge clk) a_rd <= a_re ? data_of(a_ra) : {8{$urandom()}};

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- tile model ----------------
  task automatic build_model(input logic [AW-1:0] b, s, nr, nc);
    logic [AW-1:0] a;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int r = 0; r <= int'(nr); r++) begin
      for (int c = 0; c <= int'(nc); c++) begin
        a = b + AW'(r) * s + AW'(c);
        exp_addr_q.push_back(a);
        exp_data_q.push_back({(c == int'(nc)), data_of(a)});
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [DW:0] e;
  always @(negedge clk) begin
    if (!chk_en) begin
      prev_stall = 0;
      done_due   = 0;
    end else begin
      check("fetch_done", fetch_done, done_due);
      done_due = 0;
      if (prev_stall) begin
        check("hold_valid", f_valid, 1);
        check("hold_data", f_data, prev_data);
      end
      if (a_re) begin
        issued++;
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_read: got read at %0h expected no read", a_ra);
        end else begin
          check("a_ra", a_ra, exp_addr_q.pop_front());
        end
        tests++;
        if (issued - popped > 3) begin
          fails++;
          $display("FAIL outstanding: got %0d expected at most 3", issued - popped);
        end
      end
      if (f_valid && f_ready) begin
        popped++;
        if (exp_data_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_word: got word %0h expected none", f_data);
        end else begin
          e = exp_data_q.pop_front();
          check("f_data", f_data, e[DW-1:0]);
          check("f_last", f_last, e[DW]);
          if (exp_data_q.size() == 0) done_due = 1;
        end
      end
      prev_stall = f_valid && !f_ready;
      prev_data  = f_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_tile(input logic [AW-1:0] b, s, nr, nc, input int stall, input bit extra_start);
    int cyc;
    bit seen;
    build_model(b, s, nr, nc);
    issued = 0; popped = 0;
    base_ra = b; row_stride = s; num_rows = nr; num_cols = nc;
    f_ready = 1; chk_en = 1;
    start = 1; tick(); start = 0;
    check("a_re_first", a_re, 1);
    cyc = 1;
    while (!f_valid && cyc < 20) begin tick(); cyc++; end
    check("first_valid_latency", cyc, 3);
    if (extra_start) begin start = 1; tick(); start = 0; end
    if (stall > 0) begin
      f_ready = 0;
      repeat (stall) tick();
      check("stall_a_re", a_re, 0);
      check("stall_outstanding", issued - popped, 3);
      f_ready = 1;
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (fetch_done) seen = 1;
      else tick();
    end
    check("fetch_done_seen", seen, 1);
    tick();
    check("busy_after_done", busy, 0);
    check("addr_q_left", exp_addr_q.size(), 0);
    check("data_q_left", exp_data_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_re"}, a_re, 0);
    check({tag, "_a_ra"}, a_ra, 0);
    check({tag, "_f_valid"}, f_valid, 0);
    check({tag, "_f_data"}, f_data, 0);
    check({tag, "_f_last"}, f_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fetch_done"}, fetch_done, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [AW-1:0] basic_addrs[6];
  logic          basic_last[6];
  logic [AW-1:0] wrap_addrs[4];

  initial begin
    basic_addrs = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16};
    basic_last  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    wrap_addrs  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst = 0; top_level_state = 3'd2; start = 0; f_ready = 1;
    base_ra = '0; row_stride = '0; num_rows = '0; num_cols = '0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_state", fsm_state, IDLE);
    rst = 1; tick();

    // Pin the tile model against hand-derived address lists.
    build_model(8'h10, 8'd4, 8'd1, 8'd2);
    for (int i = 0; i < 6; i++) begin
      check("model_basic_addr", exp_addr_q[i], basic_addrs[i]);
      check("model_basic_last", exp_data_q[i][DW], basic_last[i]);
    end
    build_model(8'hFE, 8'd7, 8'd0, 8'd3);
    for (int i = 0; i < 4; i++) check("model_wrap_addr", exp_addr_q[i], wrap_addrs[i]);

    run_tile(8'h10, 8'd4, 8'd1, 8'd2, 0, 0);   // basic tile
    run_tile(8'h10, 8'd4, 8'd1, 8'd2, 6, 0);   // backpressure
    run_tile(8'hFE, 8'd7, 8'd0, 8'd3, 0, 0);   // address wrap within a row
    run_tile(8'h40, 8'd1, 8'd0, 8'd0, 0, 0);   // single word
    run_tile(8'hF0, 8'h0C, 8'd2, 8'd1, 0, 0);  // row starts wrap
    run_tile(8'h10, 8'd4, 8'd1, 8'd2, 0, 1);   // start while busy

    // start with the global state outside compute
    top_level_state = 3'd1; start = 1; tick(); start = 0; top_level_state = 3'd2;
    repeat (4) begin
      check("ignored_start_busy", busy, 0);
      check("ignored_start_a_re", a_re, 0);
      tick();
    end

    // abort mid-FETCH
    chk_en = 0;
    base_ra = 8'h10; row_stride = 8'd4; num_rows = 8'd1; num_cols = 8'd2;
    start = 1; tick(); start = 0;
    tick(); tick();
    check("abort_pre_valid", f_valid, 1);
    check("abort_pre_busy", busy, 1);
    top_level_state = 3'd3; tick();
    check("abort_busy", busy, 0);
    check("abort_f_valid", f_valid, 0);
    check("abort_a_re", a_re, 0);
    check("abort_state", fsm_state, IDLE);
    top_level_state = 3'd2;
    repeat (6) begin
      tick();
      check("abort_no_valid", f_valid, 0);
      check("abort_no_done", fetch_done, 0);
      check("abort_idle", busy, 0);
    end

    // reset mid-run
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    check("rst_pre_busy", busy, 1);
    rst = 0; tick();
    check_all_zero("midrst");
    rst = 1; tick();
    check("midrst_idle", busy, 0);
    check("midrst_no_valid", f_valid, 0);

    run_tile(8'h10, 8'd4, 8'd1, 8'd2, 0, 0);   // recovery after reset

    chk_en = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
